// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Boot-time program loader. Receives a framed program image over an 8N1 UART
// line, writes it word-by-word into the instruction memory write port and
// holds the core in reset until a complete, valid image has been accepted.
// Once loaded, the core is released and the UART line is ignored until rst.
//
// Frame: A5, LEN_L, LEN_H (word count N, little-endian), N*4 data bytes
// (each word little-endian), then a checksum byte when LOADER_CHECKSUM_EN
// is defined (8-bit sum of the data bytes). With LOADER_CHECKSUM_EN
// undefined the frame ends after the last data byte.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (minimum 4)
//   IMEM_AW       instruction memory word-address width
//   TIMEOUT_CYC   maximum idle cycles between bytes inside a frame
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   uart_rx     asynchronous serial input, idle high
//   imem_we     instruction memory write strobe, one cycle per word
//   imem_addr   word address of the current write
//   imem_wdata  word being written
//   core_rst    core reset, high until a load succeeds
//   load_done   sticky: image loaded and accepted
//   load_err    sticky error, cleared when the next magic byte is accepted
// ---------------------------------------------------------------------------
module prog_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int IMEM_AW      = 12,
  parameter int TIMEOUT_CYC  = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               uart_rx,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               core_rst,
  output logic               load_done,
  output logic               load_err
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam int               TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [16:0]      MAX_WORDS = 17'(64'd1 << IMEM_AW);
  localparam logic [7:0]       MAGIC     = 8'hA5;

  // -------------------------------------------------------------------------
  // RX front end
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        rx_state, rx_state_nxt;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
  logic [2:0]       rx_bit, rx_bit_nxt;
  logic [7:0]       rx_shift, rx_shift_nxt;
  logic             rx_meta, rx_s, rx_prev;
  logic             byte_vld, frame_err;

  // Two-flop synchronizer plus one more stage for falling-edge detection.
  // Reset to the idle-high line level so reset release is not seen as a start.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential logic uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_shift <= rx_shift_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt + 1'b1;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    byte_vld     = 1'b0;
    frame_err    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_nxt = '0;
        if (rx_prev && !rx_s) rx_state_nxt = RX_START;
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (rx_cnt == HALF_BIT) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == FULL_BIT) begin
          rx_cnt_nxt   = '0;
          rx_shift_nxt = {rx_s, rx_shift[7:1]};  // LSB first
          rx_bit_nxt   = rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == FULL_BIT) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = RX_IDLE;
          byte_vld     = rx_s;
          frame_err    = !rx_s;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Frame FSM
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_RUN
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_DATA = S_CSUM;
`else
  localparam state_t S_AFTER_DATA = S_RUN;
`endif

  state_t             state, state_nxt;
  logic [15:0]        len, len_nxt;
  logic [15:0]        word_cnt, word_cnt_nxt;
  logic [1:0]         byte_idx, byte_idx_nxt;
  logic [23:0]        word_buf, word_buf_nxt;
  logic [TMO_W-1:0]   tmo_cnt, tmo_nxt;
  logic               we_nxt, done_nxt, err_nxt;
  logic [IMEM_AW-1:0] addr_nxt;
  logic [31:0]        wdata_nxt;
  logic [15:0]        frame_len;
  logic               frame_active, timeout;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         csum, csum_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      len        <= '0;
      word_cnt   <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      tmo_cnt    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= state_nxt;
      len        <= len_nxt;
      word_cnt   <= word_cnt_nxt;
      byte_idx   <= byte_idx_nxt;
      word_buf   <= word_buf_nxt;
      tmo_cnt    <= tmo_nxt;
      imem_we    <= we_nxt;
      imem_addr  <= addr_nxt;
      imem_wdata <= wdata_nxt;
      load_done  <= done_nxt;
      load_err   <= err_nxt;
`ifdef LOADER_CHECKSUM_EN
      csum       <= csum_nxt;
`endif
    end
  end

  // load_done is cleared asynchronously by rst, so core_rst follows at once.
  assign core_rst = ~load_done;

  always_comb begin
    state_nxt    = state;
    len_nxt      = len;
    word_cnt_nxt = word_cnt;
    byte_idx_nxt = byte_idx;
    word_buf_nxt = word_buf;
    we_nxt       = 1'b0;
    // The address advances the cycle after each write strobe.
    addr_nxt     = imem_addr + IMEM_AW'(imem_we);
    wdata_nxt    = imem_wdata;
    err_nxt      = load_err;
`ifdef LOADER_CHECKSUM_EN
    csum_nxt     = csum;
`endif
    frame_len    = {shift_byte(rx_shift), len[7:0]};
    frame_active = (state != S_IDLE) && (state != S_RUN);
    timeout      = frame_active && !byte_vld && (tmo_cnt == TMO_LAST);
    tmo_nxt      = (frame_active && !byte_vld) ? tmo_cnt + 1'b1 : '0;

    case (state)
      S_IDLE: begin
        if (byte_vld && rx_shift == MAGIC) begin
          state_nxt    = S_LEN0;
          err_nxt      = 1'b0;
          addr_nxt     = '0;
          word_cnt_nxt = '0;
          byte_idx_nxt = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_nxt     = '0;
`endif
        end
      end
      S_LEN0: begin
        if (byte_vld) begin
          len_nxt[7:0] = rx_shift;
          state_nxt    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (byte_vld) begin
          len_nxt = frame_len;
          if ({1'b0, frame_len} > MAX_WORDS) begin
            err_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end else if (frame_len == 16'd0) begin
            state_nxt = S_AFTER_DATA;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (byte_vld) begin
          byte_idx_nxt = byte_idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_nxt     = csum + rx_shift;
`endif
          case (byte_idx)
            2'd0: word_buf_nxt[7:0]   = rx_shift;
            2'd1: word_buf_nxt[15:8]  = rx_shift;
            2'd2: word_buf_nxt[23:16] = rx_shift;
            default: begin
              we_nxt       = 1'b1;
              wdata_nxt    = {rx_shift, word_buf};
              word_cnt_nxt = word_cnt + 16'd1;
              if (word_cnt + 16'd1 == len) state_nxt = S_AFTER_DATA;
            end
          endcase
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (byte_vld) begin
          if (rx_shift == csum) begin
            state_nxt = S_RUN;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
`endif
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase

    // Line errors abort any frame in progress; written words stay in memory.
    if (frame_active && (frame_err || timeout)) begin
      err_nxt   = 1'b1;
      state_nxt = S_IDLE;
    end

    // RUN is terminal, so load_done is simply "next state is RUN".
    done_nxt = (state_nxt == S_RUN);
  end

  function automatic logic [7:0] shift_byte(input logic [7:0] b);
    return b;
  endfunction

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//
// Self-checking bench for prog_loader with CLKS_PER_BIT=16, IMEM_AW=4 and a
// short inter-byte timeout. Whole frames are table-driven; multi-cycle corner
// cases (error clear on magic, full-capacity frame, timeout, framing error,
// start-bit glitch, reset mid-frame) are hand-written sequences. The expected
// frame ending follows LOADER_CHECKSUM_EN, matching the design build.
// ---------------------------------------------------------------------------
module tb_prog_loader;

  localparam int CPB = 16;
  localparam int AW  = 4;
  localparam int TMO = 400;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          uart_rx = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          load_done;
  logic          load_err;

  prog_loader #(
    .CLKS_PER_BIT(CPB),
    .IMEM_AW     (AW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_rst  (core_rst),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Write log and load_done rise time, sampled on the falling edge.
  int            cyc = 0;
  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  int            wr_cyc[$];
  int            ld_rise_cyc = -1;
  logic          ld_prev = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
    end
    if (load_done && !ld_prev) ld_rise_cyc = cyc;
    ld_prev = load_done;
  end

  typedef struct {
    string        name;
    bit           do_reset;
    int           nbytes;
    logic [159:0] bytes;      // first byte most significant, right-aligned
    int           exp_nwr;
    logic [63:0]  exp_wdata;  // word k at [32*k +: 32]
    bit           exp_done;
    bit           exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input bit do_reset, input int n,
                         input logic [159:0] b, input int nwr, input logic [63:0] wd,
                         input bit done, input bit err);
    vec_t v;
    v.name      = name;
    v.do_reset  = do_reset;
    v.nbytes    = n;
    v.bytes     = b;
    v.exp_nwr   = nwr;
    v.exp_wdata = wd;
    v.exp_done  = done;
    v.exp_err   = err;
    vecs.push_back(v);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    ld_rise_cyc = -1;
  endtask

  task automatic apply_reset();
    rst     = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    clear_log();
  endtask

  // Called on a falling edge; each bit lasts exactly CPB cycles.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_seq(input logic [159:0] b, input int n, input int first, input int last);
    for (int i = first; i < last; i++) send_byte(b[8*(n-1-i) +: 8], 1'b1);
  endtask

  initial begin
    logic [159:0] good_b, bad_b, garb_b, over_b, zero_b, cur_b;
    int           good_n, zero_n, cur_n;
    logic [7:0]   bb, csum;
    logic [31:0]  exp_w;

    if (CS_EN) begin
      good_b = 160'hA5_02_00_13_00_00_00_93_00_10_00_B6;
      bad_b  = 160'hA5_02_00_13_00_00_00_93_00_10_00_B7;
      good_n = 12;
      zero_b = 160'hA5_00_00_00;
      zero_n = 4;
    end else begin
      good_b = 160'hA5_02_00_13_00_00_00_93_00_10_00;
      bad_b  = good_b;
      good_n = 11;
      zero_b = 160'hA5_00_00;
      zero_n = 3;
    end
    garb_b = (160'h00_FF_5A << (8 * good_n)) | good_b;
    over_b = 160'hA5_11_00;

    add_vec("good",      1'b1, good_n,     good_b, 2, 64'h00100093_00000013, 1'b1, 1'b0);
    if (CS_EN) begin
      add_vec("csum_bad", 1'b1, good_n,    bad_b,  2, 64'h00100093_00000013, 1'b0, 1'b1);
      add_vec("resend",   1'b0, good_n,    good_b, 2, 64'h00100093_00000013, 1'b1, 1'b0);
    end
    add_vec("garbage",   1'b1, good_n + 3, garb_b, 2, 64'h00100093_00000013, 1'b1, 1'b0);
    add_vec("len_over",  1'b1, 3,          over_b, 0, 64'h0,                 1'b0, 1'b1);
    add_vec("len_zero",  1'b0, zero_n,     zero_b, 0, 64'h0,                 1'b1, 1'b0);

    // Reset values.
    apply_reset();
    check("rst_we",    32'(imem_we),   32'd0);
    check("rst_addr",  32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata,     32'd0);
    check("rst_core",  32'(core_rst),  32'd1);
    check("rst_done",  32'(load_done), 32'd0);
    check("rst_err",   32'(load_err),  32'd0);

    // Table-driven whole frames.
    for (int r = 0; r < vecs.size(); r++) begin
      if (vecs[r].do_reset) apply_reset();
      clear_log();
      cur_b = vecs[r].bytes;
      cur_n = vecs[r].nbytes;
      send_seq(cur_b, cur_n, 0, cur_n);
      repeat (20) @(negedge clk);
      check({vecs[r].name, "_nwr"}, 32'(wr_addr.size()), 32'(vecs[r].exp_nwr));
      for (int k = 0; k < vecs[r].exp_nwr && k < wr_addr.size(); k++) begin
        check({vecs[r].name, "_waddr"}, 32'(wr_addr[k]), 32'(k));
        check({vecs[r].name, "_wdata"}, wr_data[k], vecs[r].exp_wdata[32*k +: 32]);
      end
      check({vecs[r].name, "_addr"}, 32'(imem_addr), 32'(vecs[r].exp_nwr % (1 << AW)));
      check({vecs[r].name, "_done"}, 32'(load_done), 32'(vecs[r].exp_done));
      check({vecs[r].name, "_core"}, 32'(core_rst),  32'(!vecs[r].exp_done));
      check({vecs[r].name, "_err"},  32'(load_err),  32'(vecs[r].exp_err));
      // load_done rises one byte after the last write with a checksum byte,
      // or together with the last write without one.
      if (vecs[r].exp_done && vecs[r].exp_nwr > 0 && wr_cyc.size() > 0)
        check({vecs[r].name, "_done_lat"}, 32'(ld_rise_cyc - wr_cyc[wr_cyc.size()-1]),
              CS_EN ? 32'(10 * CPB) : 32'd0);
    end

    // load_err clears as soon as the next magic byte is accepted.
    if (CS_EN) begin
      apply_reset();
      send_seq(bad_b, good_n, 0, good_n);
      repeat (20) @(negedge clk);
      check("magic_err_set", 32'(load_err), 32'd1);
      send_seq(good_b, good_n, 0, 1);
      repeat (4) @(negedge clk);
      check("magic_err_clr", 32'(load_err), 32'd0);
      send_seq(good_b, good_n, 1, good_n);
      repeat (20) @(negedge clk);
      check("magic_done", 32'(load_done), 32'd1);
      check("magic_core", 32'(core_rst),  32'd0);
    end

    // Full capacity: N = 2^AW words is accepted.
    apply_reset();
    send_seq(160'hA5_10_00, 3, 0, 3);
    csum = 8'h00;
    for (int w = 0; w < 16; w++) begin
      if (w == 15) begin
        check("cap_core_pre", 32'(core_rst),  32'd1);
        check("cap_done_pre", 32'(load_done), 32'd0);
      end
      for (int k = 0; k < 4; k++) begin
        bb   = 8'(w + 16 * k);
        csum = csum + bb;
        send_byte(bb, 1'b1);
      end
    end
    if (CS_EN) send_byte(csum, 1'b1);
    repeat (20) @(negedge clk);
    check("cap_nwr", 32'(wr_addr.size()), 32'd16);
    for (int w = 0; w < 16 && w < wr_addr.size(); w++) begin
      exp_w = {8'(w + 48), 8'(w + 32), 8'(w + 16), 8'(w)};
      check("cap_waddr", 32'(wr_addr[w]), 32'(w));
      check("cap_wdata", wr_data[w], exp_w);
    end
    check("cap_done", 32'(load_done), 32'd1);
    check("cap_err",  32'(load_err),  32'd0);

    // Timeout after five data bytes: one write, then load_err.
    apply_reset();
    send_seq(good_b, good_n, 0, 8);
    repeat (100) @(negedge clk);
    check("tmo_nwr_mid", 32'(wr_addr.size()), 32'd1);
    check("tmo_err_mid", 32'(load_err),       32'd0);
    repeat (TMO) @(negedge clk);
    check("tmo_err",  32'(load_err),       32'd1);
    check("tmo_nwr",  32'(wr_addr.size()), 32'd1);
    if (wr_data.size() > 0) check("tmo_wdata", wr_data[0], 32'h00000013);
    check("tmo_core", 32'(core_rst), 32'd1);

    // Framing error mid-frame; a following frame must start from IDLE.
    apply_reset();
    send_seq(good_b, good_n, 0, 2);
    send_byte(8'h55, 1'b0);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("ferr_err", 32'(load_err), 32'd1);
    clear_log();
    send_seq(good_b, good_n, 0, good_n);
    repeat (20) @(negedge clk);
    check("ferr_done", 32'(load_done),      32'd1);
    check("ferr_err2", 32'(load_err),       32'd0);
    check("ferr_nwr",  32'(wr_addr.size()), 32'd2);

    // Short low glitch after the magic byte must not be taken as a byte.
    apply_reset();
    send_seq(good_b, good_n, 0, 1);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_seq(good_b, good_n, 1, good_n);
    repeat (20) @(negedge clk);
    check("glitch_done", 32'(load_done), 32'd1);
    check("glitch_nwr",  32'(wr_addr.size()), 32'd2);
    if (wr_data.size() > 1) check("glitch_wdata1", wr_data[1], 32'h00100093);

    // Reset asserted during DATA acts immediately, without a clock edge.
    apply_reset();
    send_seq(good_b, good_n, 0, 8);
    repeat (5) @(negedge clk);
    check("rstd_addr_pre", 32'(imem_addr), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstd_we",    32'(imem_we),   32'd0);
    check("rstd_addr",  32'(imem_addr), 32'd0);
    check("rstd_wdata", imem_wdata,     32'd0);
    check("rstd_core",  32'(core_rst),  32'd1);
    check("rstd_done",  32'(load_done), 32'd0);
    check("rstd_err",   32'(load_err),  32'd0);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    clear_log();
    send_seq(good_b, good_n, 0, good_n);
    repeat (20) @(negedge clk);
    check("rstd_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() > 1) begin
      check("rstd_waddr0", 32'(wr_addr[0]), 32'd0);
      check("rstd_wdata0", wr_data[0],      32'h00000013);
      check("rstd_waddr1", 32'(wr_addr[1]), 32'd1);
    end
    check("rstd_done2", 32'(load_done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader sitting upstream of the RV32 core top. It receives a framed program image over an 8N1 UART line, writes it word-by-word into the instruction memory's write port and holds the core in reset until a complete, valid image is loaded. After a successful load it releases the core and ignores the UART line until the next reset.

## Interface
Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 4
- IMEM_AW, 12, instruction memory word-address width (capacity 2^IMEM_AW words)
- TIMEOUT_CYC, 1000000, maximum idle cycles between bytes inside a frame

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- uart_rx  input  1  asynchronous serial input, idle high
- imem_we  output  1  instruction memory write strobe, one-cycle pulse per word
- imem_addr  output  IMEM_AW  word address of the current write
- imem_wdata  output  32  word being written
- core_rst  output  1  reset to the core; high until a load succeeds
- load_done  output  1  sticky: image loaded and accepted
- load_err  output  1  sticky error flag; cleared when the next magic byte is accepted

## Operation
- RX front end: uart_rx goes through a 2-flop synchronizer. A falling edge in idle starts a bit counter. The start bit is re-checked at mid-bit (CLKS_PER_BIT/2); if it reads high, the front end returns to idle silently. The 8 data bits are sampled LSB first at mid-bit, then the stop bit. A stop bit of 0 is a framing error.
- Each good byte produces a one-cycle internal byte_vld.
- Frame format: magic 0xA5; LEN_L; LEN_H (16-bit word count N, little-endian); N×4 data bytes (each word little-endian); checksum byte (see Configuration).
- FSM states and transitions:
  - IDLE: waits for 0xA5. Any other byte is discarded with no flag. Accepting 0xA5 clears load_err, resets the checksum and address, and goes to LEN0.
  - LEN0 → LEN1: capture LEN_L.
  - LEN1: capture LEN_H. If N > 2^IMEM_AW, set load_err and go to IDLE. If N = 0, go to CSUM, or to RUN when checksum is compiled out. Otherwise go to DATA.
  - DATA: a 2-bit byte index assembles each word; checksum += byte (mod 256). On the 4th byte, pulse imem_we. After N words, go to CSUM, or to RUN when checksum is compiled out.
  - CSUM: if the received byte equals the running sum, go to RUN. Otherwise set load_err and go to IDLE.
  - RUN: terminal. load_done=1, core_rst=0, all bytes ignored. Only rst leaves RUN.
- Errors in LEN0/LEN1/DATA/CSUM: a framing error or a timeout (TIMEOUT_CYC cycles with no byte_vld) sets load_err and returns to IDLE. Memory already written is not rolled back.
- imem_addr starts at 0 for each frame and increments after every write. A later frame overwrites from address 0.

## Timing
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, load_done=0, load_err=0. FSM returns to IDLE; RX front end returns to idle.
- byte_vld asserts at the stop-bit mid-sample cycle.
- Write latency: imem_we is high the cycle after the byte_vld of a word's 4th byte. imem_addr and imem_wdata are valid in that same cycle. imem_addr increments in the following cycle.
- load_done rises and core_rst falls together, one cycle after the byte_vld of the final byte (checksum byte, or last data byte when checksum is compiled out).
- load_err rises one cycle after the offending event.
- Timeout counter resets on every byte_vld and on entry to IDLE. It is not active in IDLE or RUN.
- rst asserted mid-frame aborts immediately. core_rst is forced to 1 asynchronously.

## Configuration
- LOADER_CHECKSUM_EN defined: a checksum byte follows the data and is verified in the CSUM state; a mismatch gives load_err.
- LOADER_CHECKSUM_EN undefined: the CSUM state and the accumulator are removed. The frame ends after the last data byte, which moves the FSM directly to RUN.

## Test plan
- CLKS_PER_BIT=16, checksum enabled; send A5 02 00 13 00 00 00 93 00 10 00 B6. Required: writes (0,0x00000013) and (1,0x00100093); load_done=1, core_rst=0 one cycle after the last byte.
- Same frame with checksum byte 0xB7. Required: two writes occur; load_err=1; core_rst stays 1. A valid frame resent afterwards clears load_err on its magic byte and completes.
- Leading garbage 00 FF 5A, then a valid frame. Required: garbage is ignored, no load_err, normal completion.
- IMEM_AW=4, length 0x0011. Required: load_err after LEN_H, no imem_we. Length 0x0000 followed by checksum 00: load_done with no writes.
- Stop the stream after 5 data bytes for TIMEOUT_CYC+1 cycles. Required: exactly one write, then load_err. A byte with stop bit 0 mid-frame: load_err, FSM in IDLE.
- Assert rst during DATA. Required: all outputs return to reset values immediately. After rst is released, a fresh frame loads correctly starting at address 0.
